// File: rtl/trng_health_monitor.sv
// Health monitor for the raw 8-bit TRNG stream: repetition-count and adaptive-proportion
// tests, startup discard, sticky alarms, and a small ready/valid output FIFO.
module trng_health_monitor #(
  parameter int unsigned RCT_CUTOFF      = 4,
  parameter int unsigned APT_WINDOW      = 64,
  parameter int unsigned APT_CUTOFF      = 13,
  parameter int unsigned STARTUP_SAMPLES = 64,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       healthy,
  output logic       rct_fail,
  output logic       apt_fail,
  input  logic       clear_fail,
  output logic [7:0] drop_cnt
);

  localparam int unsigned RCW = $clog2(RCT_CUTOFF + 1);
  localparam int unsigned ACW = $clog2(APT_CUTOFF + 1);
  localparam int unsigned SCW = $clog2(STARTUP_SAMPLES + 1);
  localparam int unsigned IW  = (APT_WINDOW > 1) ? $clog2(APT_WINDOW) : 1;
  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1,
    ST_FAIL    = 2'd2
  } state_t;

  state_t state;

  // Test state
  logic [7:0]     last;
  logic           have_last;
  logic [RCW-1:0] rcnt;
  logic [IW-1:0]  idx;
  logic [7:0]     apt_ref;
  logic [ACW-1:0] acnt;
  logic [SCW-1:0] scnt;

  // FIFO state
  logic [7:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]  rptr;
  logic [PW-1:0]  wptr;
  logic [CW-1:0]  count;

  // Combinational test evaluation and FIFO next-state
  logic           sample_en;
  logic           rct_match;
  logic [RCW-1:0] rcnt_nxt;
  logic           rct_hit;
  logic           apt_start;
  logic [ACW-1:0] acnt_nxt;
  logic           apt_hit;
  logic           any_fail;
  logic [IW-1:0]  idx_nxt;
  logic           startup_done;
  logic           pop;
  logic           push;
  logic           full;
  logic           drop;
  logic           do_push;
  logic [PW-1:0]  rptr_nxt;
  logic [PW-1:0]  wptr_nxt;
  logic [CW-1:0]  count_nxt;
  logic [7:0]     head_nxt;
  logic           clear_en;

  always_comb begin
    sample_en    = in_valid && (state != ST_FAIL);
    clear_en     = clear_fail && (state == ST_FAIL);

    rct_match    = have_last && (in_data == last);
    rcnt_nxt     = rct_match ? (rcnt + RCW'(1)) : RCW'(1);
    rct_hit      = sample_en && (rcnt_nxt == RCW'(RCT_CUTOFF));

    apt_start    = (idx == '0);
    acnt_nxt     = acnt;
    if (apt_start) begin
      acnt_nxt = ACW'(1);
    end else if (in_data == apt_ref) begin
      acnt_nxt = acnt + ACW'(1);
    end
    apt_hit      = sample_en && (acnt_nxt == ACW'(APT_CUTOFF));
    idx_nxt      = (idx == IW'(APT_WINDOW - 1)) ? '0 : (idx + IW'(1));

    any_fail     = rct_hit || apt_hit;
    startup_done = (state == ST_STARTUP) && sample_en && !any_fail &&
                   ((scnt + SCW'(1)) == SCW'(STARTUP_SAMPLES));

    pop          = out_valid && out_ready;
    push         = (state == ST_RUN) && sample_en && !any_fail;
    full         = (count == CW'(FIFO_DEPTH));
    drop         = push && full && !pop;
    do_push      = push && !drop;

    rptr_nxt     = rptr;
    if (pop) begin
      rptr_nxt = (rptr == PW'(FIFO_DEPTH - 1)) ? '0 : (rptr + PW'(1));
    end
    wptr_nxt     = wptr;
    if (do_push) begin
      wptr_nxt = (wptr == PW'(FIFO_DEPTH - 1)) ? '0 : (wptr + PW'(1));
    end
    count_nxt    = count + CW'(do_push) - CW'(pop);
    // A push landing on the new read slot bypasses the array read
    head_nxt     = (do_push && (wptr == rptr_nxt)) ? in_data : mem[rptr_nxt];
  end

  // Health-test FSM with sticky alarms and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_STARTUP;
      last      <= '0;
      have_last <= 1'b0;
      rcnt      <= '0;
      idx       <= '0;
      apt_ref   <= '0;
      acnt      <= '0;
      scnt      <= '0;
      healthy   <= 1'b0;
      rct_fail  <= 1'b0;
      apt_fail  <= 1'b0;
    end else begin
      unique case (state)
        ST_FAIL: begin
          if (clear_fail) begin
            state     <= ST_STARTUP;
            have_last <= 1'b0;
            rcnt      <= '0;
            idx       <= '0;
            acnt      <= '0;
            scnt      <= '0;
            rct_fail  <= 1'b0;
            apt_fail  <= 1'b0;
            healthy   <= 1'b0;
          end
        end
        default: begin
          if (sample_en) begin
            last      <= in_data;
            have_last <= 1'b1;
            rcnt      <= rcnt_nxt;
            idx       <= idx_nxt;
            acnt      <= acnt_nxt;
            if (apt_start) begin
              apt_ref <= in_data;
            end
            if (any_fail) begin
              state    <= ST_FAIL;
              healthy  <= 1'b0;
              rct_fail <= rct_hit;
              apt_fail <= apt_hit;
            end else if (state == ST_STARTUP) begin
              scnt <= scnt + SCW'(1);
              if (startup_done) begin
                state   <= ST_RUN;
                healthy <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  // Output FIFO; flushed on the failing sample, drop counter saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr      <= '0;
      wptr      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      drop_cnt  <= '0;
    end else begin
      if (any_fail) begin
        rptr      <= '0;
        wptr      <= '0;
        count     <= '0;
        out_valid <= 1'b0;
      end else begin
        if (do_push) begin
          mem[wptr] <= in_data;
        end
        rptr      <= rptr_nxt;
        wptr      <= wptr_nxt;
        count     <= count_nxt;
        out_valid <= (count_nxt != '0);
        if (count_nxt != '0) begin
          out_data <= head_nxt;
        end
      end
      if (clear_en) begin
        drop_cnt <= '0;
      end else if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule
